// File: rtl/fetch_ctrl_pkg.sv
// Shared CPU definitions: fetch FSM state encoding and the halt instruction word.
package fetch_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_RUN    = 2'd1,
      ST_HALTED = 2'd2
   } fetch_state_e;

   localparam int HALT_WORD_W = 9;
   localparam logic [HALT_WORD_W-1:0] HALT_WORD = '1;

endpackage : fetch_ctrl_pkg

// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: drives the external ROM address, buffers one
// instruction for decode with a valid/ready handshake, and handles redirects and halt.
module fetch_ctrl
   import fetch_ctrl_pkg::*;
#(
   parameter int A = 10,
   parameter int W = 9
) (
   input  logic          CLK,
   input  logic          reset_n,
   input  logic          start,
   input  logic [A-1:0]  start_addr,
   output logic [A-1:0]  InstAddress,
   input  logic [W-1:0]  InstOut,
   output logic          inst_valid,
   input  logic          inst_ready,
   output logic [W-1:0]  inst_q,
   output logic [A-1:0]  inst_pc,
   input  logic          redirect_valid,
   input  logic [A-1:0]  redirect_target,
   output logic          done,
   output logic [15:0]   inst_count
);

   // The halt word is all ones, so replicating one of its bits yields it at width W.
   localparam logic [W-1:0] HALT_W = {W{HALT_WORD[0]}};

   fetch_state_e  state_q, state_d;
   logic [A-1:0]  pc_q, pc_d;
   logic [W-1:0]  word_q, word_d;
   logic [A-1:0]  wpc_q, wpc_d;
   logic          valid_q, valid_d;
   logic [15:0]   count_q, count_d;

   logic          handshake;
   logic [15:0]   count_inc;

   assign handshake = valid_q & inst_ready;
   assign count_inc = (count_q == 16'hFFFF) ? count_q : count_q + 16'd1;

   always_ff @(posedge CLK or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= ST_IDLE;
         pc_q    <= '0;
         word_q  <= '0;
         wpc_q   <= '0;
         valid_q <= 1'b0;
         count_q <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         word_q  <= word_d;
         wpc_q   <= wpc_d;
         valid_q <= valid_d;
         count_q <= count_d;
      end
   end

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      word_d  = word_q;
      wpc_d   = wpc_q;
      valid_d = valid_q;
      count_d = count_q;

      // Priority: restart, then redirect (discarding the buffer uncounted), then normal flow.
      if (start) begin
         pc_d    = start_addr;
         valid_d = 1'b0;
         count_d = '0;
         state_d = ST_RUN;
      end else if (state_q != ST_IDLE && redirect_valid) begin
         pc_d    = redirect_target;
         valid_d = 1'b0;
         state_d = ST_RUN;
      end else begin
         case (state_q)
            ST_RUN: begin
               if (handshake) begin
                  count_d = count_inc;
               end
               if (!valid_q || handshake) begin
                  word_d  = InstOut;
                  wpc_d   = pc_q;
                  valid_d = 1'b1;
                  pc_d    = pc_q + 1'b1;
                  if (InstOut == HALT_W) begin
                     state_d = ST_HALTED;
                  end
               end
            end
            ST_HALTED: begin
               if (handshake) begin
                  valid_d = 1'b0;
                  count_d = count_inc;
               end
            end
            default: ;
         endcase
      end
   end

   assign InstAddress = pc_q;
   assign inst_valid  = valid_q;
   assign inst_q      = word_q;
   assign inst_pc     = wpc_q;
   assign inst_count  = count_q;
   assign done        = (state_q == ST_HALTED) && !valid_q;

endmodule : fetch_ctrl

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: directed scenarios with literal expectations plus a
// randomized run compared every cycle against a behavioural model.
module tb_fetch_ctrl;

   localparam int A = 10;
   localparam int W = 9;
   localparam int DEPTH = 1 << A;
   localparam logic [W-1:0] HALT = '1;

   logic          CLK = 1'b0;
   logic          reset_n;
   logic          start;
   logic [A-1:0]  start_addr;
   logic [A-1:0]  InstAddress;
   logic [W-1:0]  InstOut;
   logic          inst_valid;
   logic          inst_ready;
   logic [W-1:0]  inst_q;
   logic [A-1:0]  inst_pc;
   logic          redirect_valid;
   logic [A-1:0]  redirect_target;
   logic          done;
   logic [15:0]   inst_count;

   logic [W-1:0]  rom [DEPTH];

   int total = 0;
   int bad   = 0;
   bit cmp_en = 1'b0;

   always #5 CLK = ~CLK;

   assign InstOut = rom[InstAddress];

   fetch_ctrl #(.A(A), .W(W)) dut (
      .CLK             (CLK),
      .reset_n         (reset_n),
      .start           (start),
      .start_addr      (start_addr),
      .InstAddress     (InstAddress),
      .InstOut         (InstOut),
      .inst_valid      (inst_valid),
      .inst_ready      (inst_ready),
      .inst_q          (inst_q),
      .inst_pc         (inst_pc),
      .redirect_valid  (redirect_valid),
      .redirect_target (redirect_target),
      .done            (done),
      .inst_count      (inst_count)
   );

   // Behavioural model: 0 = waiting for start, 1 = fetching, 2 = halted.
   int  m_mode;
   int  m_pc;
   bit  m_has;
   int  m_word;
   int  m_wpc;
   int  m_cnt;
   bit  m_took;

   always @(posedge CLK or negedge reset_n) begin
      if (!reset_n) begin
         m_mode = 0; m_pc = 0; m_has = 0; m_word = 0; m_wpc = 0; m_cnt = 0;
      end else begin
         m_took = m_has && inst_ready;
         if (start) begin
            m_mode = 1; m_pc = int'(start_addr); m_has = 0; m_cnt = 0;
         end else if (m_mode != 0 && redirect_valid) begin
            m_mode = 1; m_pc = int'(redirect_target); m_has = 0;
         end else if (m_mode == 1) begin
            if (m_took && m_cnt < 65535) m_cnt = m_cnt + 1;
            if (!m_has || m_took) begin
               m_word = int'(rom[m_pc]);
               m_wpc  = m_pc;
               m_has  = 1;
               if (m_word == (1 << W) - 1) m_mode = 2;
               m_pc = (m_pc + 1) % DEPTH;
            end
         end else if (m_mode == 2) begin
            if (m_took) begin
               m_has = 0;
               if (m_cnt < 65535) m_cnt = m_cnt + 1;
            end
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
      end
   endtask

   always @(negedge CLK) begin
      if (cmp_en) begin
         chk("addr",  32'(InstAddress), 32'(m_pc));
         chk("valid", 32'(inst_valid),  32'(m_has));
         if (m_has) begin
            chk("inst_q",  32'(inst_q),  32'(m_word));
            chk("inst_pc", 32'(inst_pc), 32'(m_wpc));
         end
         chk("done",  32'(done),       32'(m_mode == 2 && !m_has));
         chk("count", 32'(inst_count), 32'(m_cnt));
      end
   end

   task automatic step(input bit st, input int sa, input bit rdy, input bit rv, input int rt);
      start           = st;
      start_addr      = A'(sa);
      inst_ready      = rdy;
      redirect_valid  = rv;
      redirect_target = A'(rt);
      @(posedge CLK);
      #1;
   endtask

   task automatic idle_steps(input int n, input bit rdy);
      for (int i = 0; i < n; i++) step(0, 0, rdy, 0, 0);
   endtask

   initial begin
      for (int i = 0; i < DEPTH; i++) rom[i] = 9'h001;
      reset_n = 1'b0;
      start = 0; start_addr = 0; inst_ready = 0; redirect_valid = 0; redirect_target = 0;
      repeat (3) @(posedge CLK);
      #1;
      chk("rst_addr",  32'(InstAddress), 0);
      chk("rst_valid", 32'(inst_valid), 0);
      chk("rst_done",  32'(done), 0);
      chk("rst_count", 32'(inst_count), 0);
      reset_n = 1'b1;
      cmp_en  = 1'b1;

      // Three-word program ending in halt, decode always ready.
      rom[0] = 9'b000000001; rom[1] = 9'b001001001; rom[2] = HALT;
      idle_steps(2, 1);
      chk("idle_no_fetch", 32'(inst_valid), 0);
      step(1, 0, 1, 0, 0);
      step(0, 0, 1, 0, 0);
      chk("p0_pc", 32'(inst_pc), 0); chk("p0_q", 32'(inst_q), 32'h001);
      step(0, 0, 1, 0, 0);
      chk("p1_pc", 32'(inst_pc), 1); chk("p1_q", 32'(inst_q), 32'h049);
      step(0, 0, 1, 0, 0);
      chk("p2_pc", 32'(inst_pc), 2); chk("p2_done", 32'(done), 0);
      step(0, 0, 1, 0, 0);
      chk("halt_done", 32'(done), 1); chk("halt_count", 32'(inst_count), 3);
      chk("halt_addr", 32'(InstAddress), 3);

      // Stall with pc 1 buffered.
      step(1, 0, 1, 0, 0);
      step(0, 0, 1, 0, 0);
      step(0, 0, 1, 0, 0);
      idle_steps(3, 0);
      chk("stall_pc", 32'(inst_pc), 1); chk("stall_addr", 32'(InstAddress), 2);
      chk("stall_count", 32'(inst_count), 1);
      step(0, 0, 1, 0, 0);
      chk("resume_pc", 32'(inst_pc), 2); chk("resume_count", 32'(inst_count), 2);

      // Redirect drops the buffered halt word.
      step(0, 0, 1, 1, 0);
      chk("redir_valid", 32'(inst_valid), 0); chk("redir_done", 32'(done), 0);
      chk("redir_count", 32'(inst_count), 2);
      step(0, 0, 1, 0, 0);
      chk("redir_pc", 32'(inst_pc), 0); chk("redir_done2", 32'(done), 0);

      // PC wrap from top of address space.
      rom[1023] = 9'b000000001; rom[0] = HALT;
      step(1, 1023, 1, 0, 0);
      step(0, 0, 1, 0, 0);
      chk("wrap_pc0", 32'(inst_pc), 1023);
      step(0, 0, 1, 0, 0);
      chk("wrap_pc1", 32'(inst_pc), 0); chk("wrap_addr", 32'(InstAddress), 1);
      step(0, 0, 1, 0, 0);
      chk("wrap_done", 32'(done), 1); chk("wrap_count", 32'(inst_count), 2);

      // Asynchronous reset mid-run.
      rom[0] = 9'h001;
      step(1, 4, 1, 0, 0);
      idle_steps(3, 1);
      #1 reset_n = 1'b0;
      #1;
      chk("arst_addr",  32'(InstAddress), 0); chk("arst_valid", 32'(inst_valid), 0);
      chk("arst_q",     32'(inst_q), 0);      chk("arst_pc",    32'(inst_pc), 0);
      chk("arst_count", 32'(inst_count), 0);  chk("arst_done",  32'(done), 0);
      @(posedge CLK); #1 reset_n = 1'b1;
      idle_steps(2, 1);
      chk("arst_idle", 32'(inst_valid), 0);
      step(1, 5, 1, 0, 0);
      step(0, 0, 1, 0, 0);
      chk("arst_restart_pc", 32'(inst_pc), 5);

      // Start wins over a simultaneous redirect.
      idle_steps(2, 1);
      step(1, 7, 1, 1, 3);
      chk("prio_addr", 32'(InstAddress), 7); chk("prio_count", 32'(inst_count), 0);
      chk("prio_valid", 32'(inst_valid), 0);

      // Randomized program with halts, stalls, redirects and restarts.
      for (int i = 0; i < DEPTH; i++)
         rom[i] = ($urandom_range(0, 7) == 0) ? HALT : W'($urandom_range(0, 510));
      for (int i = 0; i < 4000; i++)
         step($urandom_range(0, 39) == 0, $urandom_range(0, DEPTH - 1),
              $urandom_range(0, 9) < 7, $urandom_range(0, 11) == 0,
              $urandom_range(0, DEPTH - 1));

      // Count saturation.
      for (int i = 0; i < DEPTH; i++) rom[i] = 9'h000;
      step(1, 0, 1, 0, 0);
      idle_steps(65540, 1);
      chk("sat_count", 32'(inst_count), 32'hFFFF);

      cmp_en = 1'b0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule : tb_fetch_ctrl

// File: doc/fetch_ctrl.md
FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 Parameter A, default 10: instruction address width; PC range 0..2**A-1.
REQ-002 Parameter W, default 9: instruction word width.
REQ-003 CLK  input  1: the only clock; all state updates on its rising edge.
REQ-004 reset_n  input  1: reset, asynchronous, active-low.
REQ-005 start  input  1: single-cycle pulse that begins or restarts a program.
REQ-006 start_addr  input  A: first PC, sampled when start is high.
REQ-007 InstAddress  output  A: address to instruction ROM; equals PC register.
REQ-008 InstOut  input  W: ROM data, combinationally valid for InstAddress in the same cycle.
REQ-009 inst_valid  output  1: inst_q holds an undelivered instruction.
REQ-010 inst_ready  input  1: decode stage accepts inst_q this cycle.
REQ-011 inst_q  output  W: registered instruction to decode.
REQ-012 inst_pc  output  A: address inst_q was fetched from.
REQ-013 redirect_valid  input  1: taken branch/jump from execute.
REQ-014 redirect_target  input  A: absolute new PC.
REQ-015 done  output  1: program halted and drained.
REQ-016 inst_count  output  16: instructions delivered since last start.

Function
REQ-017 The FSM SHALL have states IDLE, RUN, HALTED.
REQ-018 IDLE: no capture; start -> PC<=start_addr, inst_valid<=0, inst_count<=0, go RUN next cycle.
REQ-019 RUN: capture SHALL occur when inst_valid==0 or (inst_valid && inst_ready): inst_q<=InstOut, inst_pc<=PC, inst_valid<=1, PC<=PC+1.
REQ-020 RUN, inst_valid && !inst_ready: inst_q, inst_pc, PC SHALL hold (stall); throughput one instruction per cycle when ready stays high.
REQ-021 PC increment SHALL wrap modulo 2**A (2**A-1 -> 0), no flag.
REQ-022 Captured word of all ones (halt) SHALL be delivered normally, and state SHALL go HALTED the same edge; PC stays at halt address+1.
REQ-023 HALTED: no capture; inst_valid clears on handshake; done SHALL be high exactly when state==HALTED and inst_valid==0.
REQ-024 redirect_valid in RUN or HALTED SHALL set PC<=redirect_target, inst_valid<=0 (buffered word discarded, not counted), state<=RUN; it overrides a capture in the same cycle.
REQ-025 redirect_valid in IDLE SHALL be ignored.
REQ-026 start in any state SHALL take priority over redirect_valid and capture, behaving as REQ-018 (restart).
REQ-027 inst_count SHALL increment on each inst_valid && inst_ready cycle and saturate at 16'hFFFF.
REQ-028 inst_ready while inst_valid==0 SHALL have no effect.

Reset
REQ-029 reset_n low SHALL asynchronously force state=IDLE, PC=0, inst_q=0, inst_pc=0, inst_valid=0, inst_count=0, done=0.
REQ-030 Reset asserted mid-RUN SHALL discard all in-flight state; after release block waits in IDLE for start.

Structure
REQ-031 FSM state enum and HALT_WORD constant (all ones, width W) SHALL live in the shared CPU package.
REQ-032 Block SHALL be a single module; ROM stays external; no sub-module required.

Verification
REQ-033 ROM {0:000000001, 1:001001001, 2:111111111}, start_addr=0, ready=1 -> inst_pc 0,1,2 on consecutive cycles; done high the cycle after halt delivered; inst_count=3.
REQ-034 Same ROM, ready low for 3 cycles with inst_pc=1 valid -> inst_q/inst_pc/InstAddress hold at 1/2; no count change; resume delivers 2 next.
REQ-035 redirect_valid with target 0 while inst_pc=2 (halt) valid -> halt word dropped, state RUN, next delivered inst_pc=0, done stays low.
REQ-036 start_addr=1023 (A=10), ROM[1023]=000000001, ROM[0]=111111111 -> delivered PCs 1023 then 0, then done.
REQ-037 reset_n low mid-RUN -> all outputs zero immediately (no clock edge); start after release restarts at start_addr.
REQ-038 start and redirect_valid in the same cycle -> PC=start_addr, inst_count=0.
